// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back arbiter with destination scoreboard
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    output logic [31:0] busy,
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  wait_q, wait_d;
    logic [31:0] busy_q, busy_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;

    logic        b_prio;
    logic        a_fire;
    logic        b_fire;
    logic        fire;
    logic [4:0]  win_addr;
    logic [31:0] win_data;

    // Ready depends only on inputs and the wait counter, never on our outputs.
    assign b_prio  = (wait_q == MAX_WAIT_C);
    assign a_ready = !rst && !(b_valid && b_prio);
    assign b_ready = !rst && (!a_valid || b_prio);

    assign a_fire   = a_valid && a_ready;
    assign b_fire   = b_valid && b_ready;
    assign fire     = a_fire || b_fire;
    assign win_addr = b_fire ? b_addr : a_addr;
    assign win_data = b_fire ? b_data : a_data;

    always_comb begin
        wait_d = wait_q;
        if (!b_valid || b_fire) begin
            wait_d = 4'd0;
        end else if (wait_q != MAX_WAIT_C) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (fire) begin
            we_d    = (win_addr != 5'd0);
            wreg_d  = win_addr;
            wdata_d = win_data;
        end
    end

    // Clear first so a same-edge issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (fire && win_addr != 5'd0) begin
            busy_d[win_addr] = 1'b0;
        end
        if (iss_valid && iss_addr != 5'd0) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= 4'd0;
            busy_q  <= 32'd0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy         = busy_q;
    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized bench for regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = 5'd0;
    logic [31:0] busy;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    int checks = 0;
    int errors = 0;

    int          m_refused = 0;
    bit [31:0]   m_busy = '0;
    bit          m_we = 1'b0;
    bit [4:0]    m_wreg = '0;
    bit [31:0]   m_wdata = '0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .busy(busy),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check handshake, advance the model, check registered state.
    task automatic step(input bit r, input bit av, input bit [4:0] aa, input bit [31:0] ad,
                        input bit bv, input bit [4:0] ba, input bit [31:0] bd,
                        input bit iv, input bit [4:0] ia);
        bit e_ar, e_br, b_turn, a_acc, b_acc;
        @(negedge clk);
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        iss_valid = iv; iss_addr = ia;
        #1;
        b_turn = (m_refused >= MAX_WAIT);
        e_ar = !r && !(bv && b_turn);
        e_br = !r && (!av || b_turn);
        check("a_ready", {31'd0, a_ready}, {31'd0, e_ar});
        check("b_ready", {31'd0, b_ready}, {31'd0, e_br});
        a_acc = av && e_ar;
        b_acc = bv && e_br;
        if (r) begin
            m_refused = 0; m_busy = '0; m_we = 0; m_wreg = '0; m_wdata = '0;
        end else begin
            m_refused = (bv && !b_acc) ? ((m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1) : 0;
            m_we = 0;
            if (b_acc) begin
                m_we = (ba != 0); m_wreg = ba; m_wdata = bd;
                if (ba != 0) m_busy[ba] = 1'b0;
            end else if (a_acc) begin
                m_we = (aa != 0); m_wreg = aa; m_wdata = ad;
                if (aa != 0) m_busy[aa] = 1'b0;
            end
            if (iv && ia != 0) m_busy[ia] = 1'b1;
            m_busy[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("write_enable", {31'd0, write_enable}, {31'd0, m_we});
        check("write_reg", {27'd0, write_reg}, {27'd0, m_wreg});
        check("write_data", write_data, m_wdata);
        check("busy", busy, m_busy);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset with both requesters valid
        step(1, 1, 5'd1, 32'hAA, 1, 5'd2, 32'hBB, 1, 5'd3);
        step(1, 1, 5'd1, 32'hAA, 1, 5'd2, 32'hBB, 1, 5'd3);
        check("reset_busy_const", busy, 32'd0);
        step(0, 1, 5'd5, 32'h11, 0, 0, 0, 0, 0);
        check("first_write_reg", {27'd0, write_reg}, 32'd5);
        check("first_write_data", write_data, 32'h11);
        idle();

        // Contention: B wins on the (MAX_WAIT+1)th cycle
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, 0, 0);
            check("contention_reg", {27'd0, write_reg}, (i == MAX_WAIT) ? 32'd2 : 32'd1);
        end
        idle();

        // Scoreboard set then clear by B
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
        check("busy7_set", {31'd0, busy[7]}, 32'd1);
        idle(); idle(); idle();
        step(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
        check("busy7_clear", {31'd0, busy[7]}, 32'd0);

        // Same-edge set and clear, then register 0
        step(0, 1, 5'd9, 32'h99, 0, 0, 0, 1, 5'd9);
        check("busy9_setwins", {31'd0, busy[9]}, 32'd1);
        step(0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 1, 5'd0);
        check("r0_no_write", {31'd0, write_enable}, 32'd0);

        // Back-to-back A writes
        for (int i = 3; i <= 6; i++) begin
            step(0, 1, 5'(i), 32'h300 + i, 0, 0, 0, 0, 0);
            check("b2b_reg", {27'd0, write_reg}, i);
        end

        // Reset mid-operation discards the in-flight write
        step(0, 1, 5'd12, 32'hC, 0, 0, 0, 1, 5'd13);
        step(1, 1, 5'd14, 32'hE, 1, 5'd15, 32'hF, 0, 0);
        idle();

        // Randomized traffic with a small address space to provoke collisions
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and destination scoreboard in front of the 32×32 register file. It shares the register file's single write port between two requesters: A, the single-cycle execute/memory pipeline, and B, the multi-cycle multiply/divide unit. It also tracks which architectural registers have an in-flight write, so that the hazard unit can stall dependent instructions. Its outputs connect directly to the register file's write_enable / write_reg / write_data inputs.

## Interface
Parameters:
- MAX_WAIT, default 3: number of consecutive cycles B may be refused before it is granted priority over A. Legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write-back.
- a_ready  out  1  A's write-back is accepted this cycle.
- a_addr  in  5  A's destination register.
- a_data  in  32  A's write data.
- b_valid  in  1  requester B has a write-back.
- b_ready  out  1  B's write-back is accepted this cycle.
- b_addr  in  5  B's destination register.
- b_data  in  32  B's write data.
- iss_valid  in  1  an instruction with a destination register is issued this cycle.
- iss_addr  in  5  destination register of the issued instruction.
- busy  out  32  per-register pending-write flags; busy[0] is always 0.
- write_enable  out  1  register-file write strobe (registered).
- write_reg  out  5  register-file write address (registered).
- write_data  out  32  register-file write data (registered).

## Operation
- A handshake transfers when valid && ready in the same cycle. Ready is combinational from the valid inputs and the internal wait counter, and never depends on this block's own outputs.
- Priority select: b_prio = (wait_cnt == MAX_WAIT).
- a_ready = !rst && !(b_valid && b_prio).
- b_ready = !rst && (!a_valid || b_prio).
- At most one transfer is accepted per cycle.
- Wait counter (4-bit):
  - Cleared when rst is high, when b_valid is low, or when B transfers.
  - Otherwise, when b_valid && !b_ready, it increments and saturates at MAX_WAIT.
- Output stage: on a transfer, the edge loads write_reg/write_data from the winner and sets write_enable = (addr != 0). With no transfer, write_enable is 0 and write_reg/write_data hold their values.
- Writes to register 0 are accepted (ready asserted) and dropped. They never raise write_enable.
- Scoreboard, evaluated at each edge:
  - Set: iss_valid && iss_addr != 0 sets busy[iss_addr].
  - Clear: an accepted transfer with addr != 0 clears busy[addr].
  - If set and clear target the same register on the same edge, set wins (a newer producer was issued).
  - busy[0] is hard-wired to 0.
- The block does not check that a transfer's address was busy. A write to a non-busy register is committed normally.

## Timing
- Reset values (at the first edge with rst high): write_enable=0, write_reg=0, write_data=0, busy=0, wait_cnt=0. While rst is high, a_ready=0 and b_ready=0.
- Reset mid-operation: a write registered in the previous cycle is discarded; write_enable is 0 from the next edge.
- Latency: a transfer in cycle N produces write_enable=1 in cycle N+1.
- The busy bit for that register falls on the same edge, so it is 0 in cycle N+1. The register file's read bypass covers the write-in-flight cycle.
- Issue-to-busy latency: iss_valid in cycle N gives busy=1 in cycle N+1.
- Throughput: one write per cycle, sustained.
- Maximum B wait: with A continuously valid, B is refused for exactly MAX_WAIT cycles and transfers on cycle MAX_WAIT+1. A is refused for that single cycle.
- After B transfers, wait_cnt restarts at 0 and A regains priority.

## Test plan
- Reset: hold rst for 2 cycles with both valids high. Expect a_ready=b_ready=0, then write_enable=0 and busy=0. After release, A (addr 5, data 0x11) gives write_enable=1, write_reg=5, write_data=0x11 one cycle later.
- Contention, MAX_WAIT=3: hold A and B valid for 5 cycles (A addr 1, B addr 2). Expect a_ready high in cycles 0–2, b_ready high in cycle 3 only, and write_reg sequence 1,1,1,2,1.
- Scoreboard: issue addr 7 in cycle 0 gives busy[7]=1 in cycle 1. A B write to 7 in cycle 4 gives busy[7]=0 and write_enable=1 in cycle 5.
- Simultaneous set/clear: iss_addr=9 and an A write to 9 on the same cycle gives busy[9]=1 afterward, and the write still commits.
- Register 0: A write to addr 0 with iss_addr=0 gives a_ready=1, write_enable=0 next cycle, and busy=0.
- Back-to-back: A valid for 4 consecutive cycles with addrs 3,4,5,6 gives 4 consecutive write_enable cycles in that order with no bubble.
